// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if
//   Bundles the three buses around data_mem_arbiter: the core load/store port (cpu_*),
//   the external loader/debug port (ext_*) and the single-port DataMemory port (mem_*),
//   plus the shared reject flag err.
//   slave  : the arbiter's view (takes requests and read data, drives acks, strobes, rdata).
//   master : the surrounding system's view (requesters plus DataMemory read data).
interface data_mem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);
  // core port
  logic                  cpu_req;
  logic                  cpu_we;
  logic [31:0]           cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_ack;
  logic                  cpu_stall;
  // external loader/debug port
  logic                  ext_req;
  logic                  ext_we;
  logic [31:0]           ext_addr;
  logic [DATA_WIDTH-1:0] ext_wdata;
  logic [DATA_WIDTH-1:0] ext_rdata;
  logic                  ext_ack;
  // DataMemory port
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_rdata;
  // rejected-access flag, pulses with the ack
  logic                  err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_rdata, ext_ack,
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata,
    output err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_rdata, ext_ack,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata,
    input  err
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares the single-port DataMemory between the MIPS core load/store path (cpu_*) and an
//   external loader/debug port (ext_*). Each grant runs IDLE -> ACCESS -> RESP: the winner's
//   byte address is range-checked and turned into a word index, DataMemory is strobed for one
//   cycle, and the winner gets a one-cycle ack (with err if the address was rejected).
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : data_mem_arbiter_if.slave (cpu_*, ext_*, mem_*, err)
// Configuration
//   DMEM_ARB_RR_EN defined   : round-robin on a tie (port opposite the last grant; CPU first after reset)
//   DMEM_ARB_RR_EN undefined : fixed priority, CPU wins every tie
module data_mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h10010000
) (
  input logic              clk,
  input logic              reset,
  data_mem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]            state, stateNext;
  logic                  grantExt, grantExtNext;   // 1 = current transaction belongs to ext
  logic                  accWe, accWeNext;
  logic                  accOk, accOkNext;

  logic                  anyReq;
  logic                  pickExt;
  logic                  selWe;
  logic                  selOk;
  logic [31:0]           selAddr;
  logic [31:0]           selOff;
  logic [DATA_WIDTH-1:0] selWdata;

  logic [ADDR_WIDTH-1:0] memAddrNext;
  logic [DATA_WIDTH-1:0] memWdataNext;
  logic                  memWeNext, memReNext;
  logic                  cpuAckNext, extAckNext, errNext;
  logic [DATA_WIDTH-1:0] cpuRdataNext, extRdataNext;
  logic [DATA_WIDTH-1:0] respData;

  assign anyReq = bus.cpu_req | bus.ext_req;

  // Winner selection; only consumed while IDLE
`ifdef DMEM_ARB_RR_EN
  logic lastGrantExt;

  // Remembers who was granted last; starts at EXT so the first tie goes to the CPU
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lastGrantExt <= 1'b1;
    end else if (state == IDLE && anyReq) begin
      lastGrantExt <= pickExt;
    end
  end

  assign pickExt = bus.ext_req & (~bus.cpu_req | ~lastGrantExt);
`else
  assign pickExt = bus.ext_req & ~bus.cpu_req;
`endif

  // Winner's request fields and address decode
  assign selWe    = pickExt ? bus.ext_we    : bus.cpu_we;
  assign selAddr  = pickExt ? bus.ext_addr  : bus.cpu_addr;
  assign selWdata = pickExt ? bus.ext_wdata : bus.cpu_wdata;
  assign selOff   = selAddr - BASE_ADDR;
  // Word-aligned, not below the base, and word offset inside 2**ADDR_WIDTH
  assign selOk    = (selAddr[1:0] == 2'b00) && (selAddr >= BASE_ADDR)
                    && ((selOff >> (ADDR_WIDTH + 2)) == 32'd0);

  // Load data captured from the combinational DataMemory read during ACCESS
  assign respData = (accOk && !accWe) ? bus.mem_rdata : '0;

  // Next state and next registered outputs
  always_comb begin
    stateNext    = state;
    grantExtNext = grantExt;
    accWeNext    = accWe;
    accOkNext    = accOk;
    memAddrNext  = '0;
    memWdataNext = '0;
    memWeNext    = 1'b0;
    memReNext    = 1'b0;
    cpuAckNext   = 1'b0;
    extAckNext   = 1'b0;
    cpuRdataNext = '0;
    extRdataNext = '0;
    errNext      = 1'b0;

    case (state)
      IDLE: begin
        if (anyReq) begin
          stateNext    = ACCESS;
          grantExtNext = pickExt;
          accWeNext    = selWe;
          accOkNext    = selOk;
          memAddrNext  = selOff[ADDR_WIDTH+1:2];
          memWdataNext = selWdata;
          memWeNext    = selWe & selOk;
          memReNext    = ~selWe & selOk;
        end
      end
      ACCESS: begin
        stateNext = RESP;
        errNext   = ~accOk;
        if (grantExt) begin
          extAckNext   = 1'b1;
          extRdataNext = respData;
        end else begin
          cpuAckNext   = 1'b1;
          cpuRdataNext = respData;
        end
      end
      RESP: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the memory strobes immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      grantExt      <= 1'b0;
      accWe         <= 1'b0;
      accOk         <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_re    <= 1'b0;
      bus.cpu_ack   <= 1'b0;
      bus.ext_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.ext_rdata <= '0;
      bus.err       <= 1'b0;
    end else begin
      state         <= stateNext;
      grantExt      <= grantExtNext;
      accWe         <= accWeNext;
      accOk         <= accOkNext;
      bus.mem_addr  <= memAddrNext;
      bus.mem_wdata <= memWdataNext;
      bus.mem_we    <= memWeNext;
      bus.mem_re    <= memReNext;
      bus.cpu_ack   <= cpuAckNext;
      bus.ext_ack   <= extAckNext;
      bus.cpu_rdata <= cpuRdataNext;
      bus.ext_rdata <= extRdataNext;
      bus.err       <= errNext;
    end
  end

  // Core stall is combinational so the pipeline freezes in the request cycle
  assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_ack;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter
//   Directed scenarios plus two randomized requesters, checked every cycle against a
//   transaction-level model of the arbiter and a shadow copy of DataMemory.
//   DMEM_ARB_RR_EN selects the round-robin expectations.
module tb_data_mem_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h10010000;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   nChecks = 0;
  int   nFail   = 0;

  data_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  data_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // DataMemory: combinational read, write on the rising edge
  logic [DW-1:0] dmem [DEPTH] = '{default: '0};
  assign bus.mem_rdata = dmem[bus.mem_addr];
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) dmem[bus.mem_addr] <= bus.mem_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          cpuAck;
    logic          extAck;
    logic          err;
    logic [DW-1:0] rdata;
    logic          we;
    logic          re;
    logic [AW-1:0] idx;
    logic [DW-1:0] wdata;
  } expT;

  expT           curExp = '0;   // what the outputs must show in the current cycle
  expT           nxtExp = '0;   // what they must show in the following cycle
  logic [DW-1:0] refMem [DEPTH] = '{default: '0};
  longint        cyc    = 0;
  longint        freeAt = 0;    // first cycle in which a new request can be taken
  bit            mUseExt, mWe, mOk;
  logic [31:0]   mAddr;
  logic [DW-1:0] mData;
  logic [AW-1:0] mIdx;
`ifdef DMEM_ARB_RR_EN
  bit            lastExt = 1'b1;
`endif

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      curExp = '0;
      nxtExp = '0;
      freeAt = 0;
`ifdef DMEM_ARB_RR_EN
      lastExt = 1'b1;
`endif
    end else begin
      if (curExp.we) refMem[curExp.idx] = curExp.wdata;
      curExp = nxtExp;
      nxtExp = '0;
      cyc++;
      if (cyc >= freeAt && (bus.cpu_req || bus.ext_req)) begin
`ifdef DMEM_ARB_RR_EN
        mUseExt = (bus.cpu_req && bus.ext_req) ? !lastExt : bus.ext_req;
        lastExt = mUseExt;
`else
        mUseExt = !bus.cpu_req;
`endif
        mAddr = mUseExt ? bus.ext_addr  : bus.cpu_addr;
        mWe   = mUseExt ? bus.ext_we    : bus.cpu_we;
        mData = mUseExt ? bus.ext_wdata : bus.cpu_wdata;
        mOk   = (mAddr % 4 == 0) && (mAddr >= BASE) && (((mAddr - BASE) / 4) < DEPTH);
        mIdx  = AW'((mAddr - BASE) / 4);
        curExp       = '0;
        curExp.we    = mWe && mOk;
        curExp.re    = !mWe && mOk;
        curExp.idx   = mIdx;
        curExp.wdata = mData;
        nxtExp.cpuAck = !mUseExt;
        nxtExp.extAck = mUseExt;
        nxtExp.err    = !mOk;
        nxtExp.rdata  = (mOk && !mWe) ? refMem[mIdx] : '0;
        freeAt = cyc + 3;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    chk("cpu_ack",   bus.cpu_ack,   curExp.cpuAck);
    chk("ext_ack",   bus.ext_ack,   curExp.extAck);
    chk("err",       bus.err,       curExp.err);
    chk("mem_we",    bus.mem_we,    curExp.we);
    chk("mem_re",    bus.mem_re,    curExp.re);
    chk("cpu_stall", bus.cpu_stall, bus.cpu_req & ~curExp.cpuAck);
    if (curExp.we || curExp.re) chk("mem_addr", bus.mem_addr, curExp.idx);
    if (curExp.we) chk("mem_wdata", bus.mem_wdata, curExp.wdata);
    if (curExp.cpuAck) chk("cpu_rdata", bus.cpu_rdata, curExp.rdata);
    if (curExp.extAck) chk("ext_rdata", bus.ext_rdata, curExp.rdata);
  end

  // Order in which acks appear (0 = cpu, 1 = ext)
  bit ackOrder [$];
  always @(negedge clk) begin
    if (bus.cpu_ack === 1'b1) ackOrder.push_back(1'b0);
    if (bus.ext_ack === 1'b1) ackOrder.push_back(1'b1);
  end

  // ---------------- stimulus helpers ----------------
  bit            rErr;
  logic [DW-1:0] rData;
  int            rLat, rStrobes;
  logic [AW-1:0] rSAddr;
  logic [DW-1:0] rSData;

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  // One transaction; called 1 time unit after a falling edge, returns likewise
  task automatic doTxn(input bit isExt, input bit we, input logic [31:0] addr, input logic [DW-1:0] wd,
                       output bit gotErr, output logic [DW-1:0] rd, output int lat, output int strobes,
                       output logic [AW-1:0] sAddr, output logic [DW-1:0] sData);
    bit done;
    done = 1'b0; lat = 0; strobes = 0; gotErr = 1'b0; rd = '0; sAddr = '0; sData = '0;
    if (isExt) begin
      bus.ext_we = we; bus.ext_addr = addr; bus.ext_wdata = wd; bus.ext_req = 1'b1;
    end else begin
      bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd; bus.cpu_req = 1'b1;
    end
    while (!done && lat < 300) begin
      @(negedge clk);
      lat++;
      if (bus.mem_we === 1'b1 || bus.mem_re === 1'b1) begin
        strobes++; sAddr = bus.mem_addr; sData = bus.mem_wdata;
      end
      if ((isExt ? bus.ext_ack : bus.cpu_ack) === 1'b1) begin
        done = 1'b1;
        rd = isExt ? bus.ext_rdata : bus.cpu_rdata;
        gotErr = bus.err;
      end
    end
    #1;
    if (isExt) bus.ext_req = 1'b0; else bus.cpu_req = 1'b0;
    chk("ack_within_bound", done, 1);
  endtask

  task automatic txn(input bit isExt, input bit we, input logic [31:0] addr, input logic [DW-1:0] wd);
    doTxn(isExt, we, addr, wd, rErr, rData, rLat, rStrobes, rSAddr, rSData);
  endtask

  task automatic quickTxn(input bit isExt, input bit we, input logic [31:0] addr, input logic [DW-1:0] wd);
    bit e; logic [DW-1:0] d; int l, s; logic [AW-1:0] a; logic [DW-1:0] w;
    doTxn(isExt, we, addr, wd, e, d, l, s, a, w);
  endtask

  function automatic logic [31:0] randAddr();
    int unsigned k;
    k = $urandom_range(0, 9);
    case (k)
      0: randAddr = BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
      1: randAddr = BASE + 32'h1000 + 4 * $urandom_range(0, 255);
      2: randAddr = BASE - 4 * $urandom_range(1, 64);
      3: randAddr = BASE + 32'hFFC;
      default: randAddr = BASE + 4 * $urandom_range(0, 15);
    endcase
  endfunction

  task automatic randRequester(input bit isExt, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) sync();
      quickTxn(isExt, 1'($urandom_range(0, 1)), randAddr(), $urandom);
    end
  endtask

  task automatic resetDut();
    sync();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  int ackPos [$];
  logic [DW-1:0] memDiffs;

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = '0; bus.ext_wdata = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_we",  bus.mem_we,  0);
    chk("rst_mem_re",  bus.mem_re,  0);
    chk("rst_cpu_ack", bus.cpu_ack, 0);
    chk("rst_err",     bus.err,     0);
    #1 reset = 1'b1;

    // 1: store then load of word 2
    txn(1'b0, 1'b1, BASE + 32'h8, 32'hDEADBEEF);
    chk("t1_store_latency", rLat, 2);
    chk("t1_store_strobes", rStrobes, 1);
    chk("t1_store_mem_addr", rSAddr, 2);
    chk("t1_store_mem_wdata", rSData, 32'hDEADBEEF);
    chk("t1_store_err", rErr, 0);
    txn(1'b0, 1'b0, BASE + 32'h8, '0);
    chk("t1_load_rdata", rData, 32'hDEADBEEF);
    chk("t1_load_err", rErr, 0);

    // 3: misaligned load
    sync();
    txn(1'b0, 1'b0, BASE + 32'h2, '0);
    chk("t3_latency", rLat, 2);
    chk("t3_strobes", rStrobes, 0);
    chk("t3_err", rErr, 1);
    chk("t3_rdata", rData, 0);

    // 4: ext stores at both ends, then out-of-range and below-base rejects
    txn(1'b1, 1'b1, BASE, 32'h11111111);
    txn(1'b1, 1'b1, BASE + 32'hFFC, 32'h22222222);
    txn(1'b1, 1'b1, 32'h10011000, 32'hBAD0BAD0);
    chk("t4_above_err", rErr, 1);
    chk("t4_above_strobes", rStrobes, 0);
    txn(1'b1, 1'b1, 32'h1000FFFC, 32'hBAD1BAD1);
    chk("t4_below_err", rErr, 1);
    chk("t4_below_strobes", rStrobes, 0);
    txn(1'b1, 1'b0, BASE, '0);
    chk("t4_word0", rData, 32'h11111111);
    txn(1'b1, 1'b0, BASE + 32'hFFC, '0);
    chk("t4_word1023", rData, 32'h22222222);

    // 2: simultaneous requests right after reset
    resetDut();
    ackOrder.delete();
    fork
      begin
        quickTxn(1'b0, 1'b0, BASE + 32'h8, '0);
        quickTxn(1'b0, 1'b0, BASE, '0);
      end
      quickTxn(1'b1, 1'b0, BASE + 32'hFFC, '0);
    join
    chk("t2_ack_count", ackOrder.size(), 3);
    chk("t2_first_grant", ackOrder[0], 0);
    chk("t2_second_grant", ackOrder[1], RR_MODE ? 1 : 0);

    // 5: reset in the ACCESS cycle of a store
    repeat (3) sync();
    bus.cpu_we = 1'b1; bus.cpu_addr = BASE + 32'hC; bus.cpu_wdata = 32'hCAFEF00D; bus.cpu_req = 1'b1;
    @(negedge clk);
    chk("t5_store_strobe", bus.mem_we, 1);
    #1 reset = 1'b0;
    #1;
    chk("t5_rst_mem_we",  bus.mem_we,  0);
    chk("t5_rst_mem_re",  bus.mem_re,  0);
    chk("t5_rst_cpu_ack", bus.cpu_ack, 0);
    chk("t5_rst_err",     bus.err,     0);
    bus.cpu_req = 1'b0;
    #1 reset = 1'b1;
    txn(1'b0, 1'b0, BASE, '0);
    chk("t5_load_latency", rLat, 2);
    chk("t5_load_rdata", rData, 32'h11111111);
    chk("t5_load_err", rErr, 0);

    // 6: ext_req held for 9 cycles
    repeat (2) sync();
    bus.ext_we = 1'b0; bus.ext_addr = BASE + 32'h4; bus.ext_req = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (bus.ext_ack === 1'b1) ackPos.push_back(i);
    end
    #1 bus.ext_req = 1'b0;
    chk("t6_ack_count", ackPos.size(), 3);
    chk("t6_first_ack", ackPos[0], 2);
    chk("t6_spacing_1", ackPos[1] - ackPos[0], 3);
    chk("t6_spacing_2", ackPos[2] - ackPos[1], 3);

    // Random traffic from both ports
    fork
      randRequester(1'b0, 150);
      randRequester(1'b1, 150);
    join
    repeat (5) sync();

    // Final memory image against the shadow copy
    memDiffs = '0;
    for (int w = 0; w < int'(DEPTH); w++) begin
      if (dmem[w] !== refMem[w]) memDiffs = memDiffs + 1'b1;
    end
    chk("memory_image_diffs", memDiffs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
